// File: rtl/servo_pwm_scheduler_pkg.sv
// Shared types and default constants for the servo drive path.
// Holds the FSM state type, the pulse-width bus width, the default frame and
// clamp limits also used by the pixel->pulse-width mapper, and the helper
// that derives an axis centre from its limits.
package servo_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int unsigned PWM_W = 21;

  localparam int unsigned DEF_PERIOD_CYCLES = 2_000_000;
  localparam int unsigned DEF_MIN_X         = 125_000;
  localparam int unsigned DEF_MAX_X         = 375_000;
  localparam int unsigned DEF_MIN_Y         = 155_000;
  localparam int unsigned DEF_MAX_Y         = 290_000;
  localparam int unsigned DEF_MAX_STEP      = 20_000;

  // Centre of a legal range; the power-on position of an axis.
  function automatic int unsigned centre_of(input int unsigned lo, input int unsigned hi);
    return (lo + hi) / 2;
  endfunction

endpackage

// File: rtl/servo_pwm_scheduler_if.sv
// Target handshake between the pulse-width mapper (master) and the scheduler (slave).
// Signals: target_valid_in, target_x_in, target_y_in (master -> slave),
//          target_ready_out (slave -> master).
interface servo_pwm_scheduler_if;
  import servo_pkg::*;

  logic             target_valid_in;
  logic             target_ready_out;
  logic [PWM_W-1:0] target_x_in;
  logic [PWM_W-1:0] target_y_in;

  modport master (output target_valid_in, target_x_in, target_y_in,
                  input  target_ready_out);
  modport slave  (input  target_valid_in, target_x_in, target_y_in,
                  output target_ready_out);
endinterface

// File: rtl/servo_pwm_scheduler_slew.sv
// Per-axis combinational helper: clamps a raw target into [MIN, MAX] and
// computes the committed width one frame later, moved toward pending by at
// most MAX_STEP.
// Ports: raw (requested width), pending, committed (current registers),
//        clamped_c (raw limited to range), stepped_c (next committed width).
module servo_slew
  import servo_pkg::*;
#(
  parameter int unsigned MIN      = DEF_MIN_X,
  parameter int unsigned MAX      = DEF_MAX_X,
  parameter int unsigned MAX_STEP = DEF_MAX_STEP
) (
  input  logic [PWM_W-1:0] raw,
  input  logic [PWM_W-1:0] pending,
  input  logic [PWM_W-1:0] committed,
  output logic [PWM_W-1:0] clamped_c,
  output logic [PWM_W-1:0] stepped_c
);

  localparam int unsigned DIFF_W = PWM_W + 1;

  logic signed [DIFF_W-1:0] diff;

  // Clamp into the legal window.
  always_comb begin
    clamped_c = raw;
    if (raw < PWM_W'(MIN)) begin
      clamped_c = PWM_W'(MIN);
    end else if (raw > PWM_W'(MAX)) begin
      clamped_c = PWM_W'(MAX);
    end
  end

  // Signed distance one bit wider than the widths, so it can never wrap.
  always_comb begin
    diff      = $signed({1'b0, pending}) - $signed({1'b0, committed});
    stepped_c = pending;
    if (diff > $signed(DIFF_W'(MAX_STEP))) begin
      stepped_c = committed + PWM_W'(MAX_STEP);
    end else if (diff < -$signed(DIFF_W'(MAX_STEP))) begin
      stepped_c = committed - PWM_W'(MAX_STEP);
    end
  end

endmodule

// File: rtl/servo_pwm_scheduler.sv
// Two-axis servo PWM scheduler. Targets arrive on a valid/ready handshake,
// are clamped into pending registers, and are committed (slew-limited) only
// at frame boundaries. PWM is generated with an OFF/ARM/RUN/DRAIN sequence so
// the servos only ever see whole pulses.
// Ports: clk_in, rst_in (async, active high), enable_in (drive request),
//        tgt (target handshake, slave side), pwm_x_out/pwm_y_out,
//        period_start_out (frame start while running), pos_x_out/pos_y_out
//        (committed widths), settled_out (committed == pending on both axes).
module servo_pwm_scheduler
  import servo_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES = DEF_PERIOD_CYCLES,
  parameter int unsigned MIN_X         = DEF_MIN_X,
  parameter int unsigned MAX_X         = DEF_MAX_X,
  parameter int unsigned MIN_Y         = DEF_MIN_Y,
  parameter int unsigned MAX_Y         = DEF_MAX_Y,
  parameter int unsigned MAX_STEP      = DEF_MAX_STEP
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  enable_in,
  servo_pwm_scheduler_if.slave  tgt,
  output logic                  pwm_x_out,
  output logic                  pwm_y_out,
  output logic                  period_start_out,
  output logic [PWM_W-1:0]      pos_x_out,
  output logic [PWM_W-1:0]      pos_y_out,
  output logic                  settled_out
);

  localparam int unsigned CNT_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [PWM_W-1:0] CENTRE_X = PWM_W'(centre_of(MIN_X, MAX_X));
  localparam logic [PWM_W-1:0] CENTRE_Y = PWM_W'(centre_of(MIN_Y, MAX_Y));

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             boundary;
  logic             accept;
  logic             ready;
  logic             drive_x;
  logic             drive_y;
  logic [PWM_W-1:0] pend_x, pend_y;
  logic [PWM_W-1:0] pend_x_nxt, pend_y_nxt;
  logic [PWM_W-1:0] com_x_nxt, com_y_nxt;
  logic [PWM_W-1:0] clamp_x, clamp_y;
  logic [PWM_W-1:0] step_x, step_y;

  servo_slew #(.MIN(MIN_X), .MAX(MAX_X), .MAX_STEP(MAX_STEP)) u_slew_x (
    .raw       (tgt.target_x_in),
    .pending   (pend_x),
    .committed (pos_x_out),
    .clamped_c (clamp_x),
    .stepped_c (step_x)
  );

  servo_slew #(.MIN(MIN_Y), .MAX(MAX_Y), .MAX_STEP(MAX_STEP)) u_slew_y (
    .raw       (tgt.target_y_in),
    .pending   (pend_y),
    .committed (pos_y_out),
    .clamped_c (clamp_y),
    .stepped_c (step_y)
  );

  assign tgt.target_ready_out = ready;

  // Next-cycle values; registered outputs are computed from these so they
  // line up with the count they describe.
  always_comb begin
    boundary   = (count == LAST);
    count_nxt  = boundary ? '0 : count + CNT_W'(1);
    accept     = tgt.target_valid_in && ready;
    pend_x_nxt = accept ? clamp_x : pend_x;
    pend_y_nxt = accept ? clamp_y : pend_y;
    com_x_nxt  = boundary ? step_x : pos_x_out;
    com_y_nxt  = boundary ? step_y : pos_y_out;
    drive_x    = 32'(count_nxt) < 32'(com_x_nxt);
    drive_y    = 32'(count_nxt) < 32'(com_y_nxt);
  end

  // Frame counter, target registers and status outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count       <= '0;
      pend_x      <= CENTRE_X;
      pend_y      <= CENTRE_Y;
      pos_x_out   <= CENTRE_X;
      pos_y_out   <= CENTRE_Y;
      settled_out <= 1'b1;
      ready       <= 1'b1;
    end else begin
      count       <= count_nxt;
      pend_x      <= pend_x_nxt;
      pend_y      <= pend_y_nxt;
      pos_x_out   <= com_x_nxt;
      pos_y_out   <= com_y_nxt;
      settled_out <= (pend_x_nxt == com_x_nxt) && (pend_y_nxt == com_y_nxt);
      ready       <= (count_nxt != LAST);
    end
  end

  // Drive sequencer; PWM only starts at a frame edge and DRAIN finishes the
  // frame in progress, so no runt pulse is ever emitted.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state            <= OFF;
      pwm_x_out        <= 1'b0;
      pwm_y_out        <= 1'b0;
      period_start_out <= 1'b0;
    end else begin
      pwm_x_out        <= 1'b0;
      pwm_y_out        <= 1'b0;
      period_start_out <= 1'b0;
      case (state)
        OFF: begin
          if (enable_in) state <= ARM;
        end
        ARM: begin
          if (boundary) begin
            if (enable_in) begin
              state            <= RUN;
              pwm_x_out        <= drive_x;
              pwm_y_out        <= drive_y;
              period_start_out <= 1'b1;
            end else begin
              state <= OFF;
            end
          end
        end
        RUN: begin
          pwm_x_out <= drive_x;
          pwm_y_out <= drive_y;
          if (!enable_in) begin
            state <= DRAIN;
          end else begin
            period_start_out <= boundary;
          end
        end
        DRAIN: begin
          if (enable_in) begin
            state            <= RUN;
            pwm_x_out        <= drive_x;
            pwm_y_out        <= drive_y;
            period_start_out <= boundary;
          end else if (boundary) begin
            state <= OFF;
          end else begin
            pwm_x_out <= drive_x;
            pwm_y_out <= drive_y;
          end
        end
        default: state <= OFF;
      endcase
    end
  end

endmodule
